console_usb_send: RTL and testbench
===================================

Name: console_usb_send

Overview:
- Per-lane USB packet transmitter. Sits directly downstream of the console USB control FSM.
- Eight instances, lanes 0..7, together form the fs_send / fd_send[0:7] handshake.
- On fs_send, each instance latches the requested bag type, data index and device index. It serialises a 9-byte packet onto a byte-wide valid/ready stream toward the USB FIFO.
- It then raises fd_send and holds it until fs_send is released.

Parameters:
- LANE_ID, 8'h00, lane number embedded in the packet (0..7).
- TIMEOUT_NUM, 32'd1_000_000, consecutive stalled cycles (tx_valid=1, tx_ready=0) before the packet is aborted.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-high
- fs_send  input  1  send request from control FSM; level, held until fd_send seen
- fd_send  output  1  this lane's send-done; level
- send_btype  input  4  bag type (0001 conf, 1001 conv, 1011 link); stable when fs_send rises
- data_idx  input  4  data index; stable when fs_send rises
- device_idx  input  32  device identifier; stable when fs_send rises
- tx_data  output  8  packet byte toward USB FIFO
- tx_valid  output  1  tx_data valid
- tx_ready  input  1  FIFO accepts byte when tx_valid & tx_ready
- tx_err  output  1  sticky: last packet aborted by timeout

Behaviour:
- Reset values: fd_send=0, tx_valid=0, tx_data=8'h00, tx_err=0, state=IDLE, byte counter=0, stall counter=0, latched fields=0.
- Packet, in byte order:
  - B0 = 8'h55, B1 = 8'hAA
  - B2 = {btype, data_idx}
  - B3..B6 = device_idx[31:24], [23:16], [15:8], [7:0]
  - B7 = LANE_ID
  - B8 = checksum = (B2+B3+B4+B5+B6+B7) mod 256, 8-bit wrap
- State machine (one-hot):
  - IDLE: if fs_send=1, latch send_btype/data_idx/device_idx and clear tx_err -> LOAD; else stay.
  - LOAD: one cycle. Compute checksum from latched fields, clear byte counter and stall counter -> SEND.
  - SEND: tx_valid=1, tx_data = byte[counter].
    - On handshake: counter+1 and stall counter cleared. If the handshake is on B8 -> DONE; else stay.
    - On stall: stall counter+1. When stall counter == TIMEOUT_NUM-1 with no handshake that cycle, set tx_err=1 -> DONE.
  - DONE: tx_valid=0, fd_send=1. If fs_send=0 -> IDLE, with fd_send low from the next cycle.
- Latency: first byte is valid 2 cycles after fs_send is sampled high (IDLE -> LOAD -> SEND).
  - With tx_ready tied high, the packet takes 9 cycles.
  - fd_send rises on the cycle after the B8 handshake.
- Stream rules:
  - tx_data is registered and changes only after a handshake or when entering SEND.
  - tx_valid never drops inside SEND, except on timeout abort.
- fs_send dropping during LOAD/SEND: ignored. The packet completes, DONE lasts one cycle (fs_send=0), then IDLE.
- fs_send re-asserted on the IDLE cycle right after DONE: starts a new packet normally.
- Timeout abort: remaining bytes are not sent. fd_send still asserts so the upstream FSM cannot hang. tx_err holds until the next packet start.
- Input changes after latching do not affect the packet in flight.
- rst asserted mid-packet: immediately return to reset values. No partial resume.

Test Plan:
- Basic packet, tx_ready=1, LANE_ID=3, btype=4'hB, data_idx=5, device_idx=32'h13579BDF:
  - stream is 55 AA B5 13 57 9B DF 03 9C
  - first tx_valid 2 cycles after fs_send; fd_send 1 cycle after the 9C handshake; fd_send falls 1 cycle after fs_send=0.
- Backpressure: same packet with tx_ready toggling 1-0-0-1 repeatedly -> identical 9 bytes, none duplicated or skipped; tx_data stable while stalled.
- Checksum wrap: btype=4'hF, data_idx=4'hF, device_idx=32'hFFFFFFFF, LANE_ID=7 -> B2=FF, B8=(FF*5+07) mod 256 = 8'h02.
- Timeout: TIMEOUT_NUM=16, tx_ready=0 from B3 -> after 16 stalled cycles tx_valid=0, tx_err=1, fd_send=1. The next fs_send clears tx_err and a full packet follows.
- Early release / back-to-back: drop fs_send during B4 -> all 9 bytes sent, fd_send high 1 cycle. Immediately re-raise fs_send with btype=4'h1 -> B2=8'h15 (data_idx=5).
- Reset mid-packet: assert rst during B5 -> tx_valid, fd_send and tx_err go 0 asynchronously. After release, fs_send produces a complete packet from B0.

Source files
------------

// File: rtl/console_usb_send.sv
// Per-lane USB packet transmitter: latches a send request, streams a 9-byte
// packet over a byte-wide valid/ready link, then holds fd_send until released.
module console_usb_send #(
    parameter logic [7:0]  LANE_ID     = 8'h00,
    parameter logic [31:0] TIMEOUT_NUM = 32'd1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fs_send,
    output logic        fd_send,
    input  logic [3:0]  send_btype,
    input  logic [3:0]  data_idx,
    input  logic [31:0] device_idx,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_err
);

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        LOAD = 4'b0010,
        SEND = 4'b0100,
        DONE = 4'b1000
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  btype_q;
    logic [3:0]  didx_q;
    logic [31:0] dev_q;
    logic [7:0]  csum_q;
    logic [3:0]  byte_cnt;
    logic [3:0]  nxt_idx;
    logic [31:0] stall_cnt;
    logic [7:0]  nxt_byte;
    logic        hs;
    logic        stall;
    logic        timeout;

    // Stream contract: a byte moves on every cycle where tx_valid and tx_ready
    // are both high; once raised, tx_valid and tx_data hold until that happens
    // (only a timeout abort may drop tx_valid without a transfer).
    assign hs      = (state == SEND) && tx_ready;
    assign stall   = (state == SEND) && !tx_ready;
    assign timeout = stall && (stall_cnt == TIMEOUT_NUM - 32'd1);
    assign nxt_idx = byte_cnt + 4'd1;

    always_comb begin
        nxt_byte = 8'h00;
        case (nxt_idx)
            4'd1:    nxt_byte = 8'hAA;
            4'd2:    nxt_byte = {btype_q, didx_q};
            4'd3:    nxt_byte = dev_q[31:24];
            4'd4:    nxt_byte = dev_q[23:16];
            4'd5:    nxt_byte = dev_q[15:8];
            4'd6:    nxt_byte = dev_q[7:0];
            4'd7:    nxt_byte = LANE_ID;
            4'd8:    nxt_byte = csum_q;
            default: nxt_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tx_valid  = 1'b0;
        fd_send   = 1'b0;
        case (state)
            IDLE: if (fs_send) state_nxt = LOAD;
            LOAD: state_nxt = SEND;
            SEND: begin
                tx_valid = 1'b1;
                if ((hs && byte_cnt == 4'd8) || timeout) state_nxt = DONE;
            end
            DONE: begin
                fd_send = 1'b1;
                if (!fs_send) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btype_q   <= 4'h0;
            didx_q    <= 4'h0;
            dev_q     <= 32'h0;
            csum_q    <= 8'h00;
            byte_cnt  <= 4'd0;
            stall_cnt <= 32'd0;
            tx_data   <= 8'h00;
            tx_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fs_send) begin
                        btype_q <= send_btype;
                        didx_q  <= data_idx;
                        dev_q   <= device_idx;
                        tx_err  <= 1'b0;
                    end
                end
                LOAD: begin
                    csum_q    <= {btype_q, didx_q} + dev_q[31:24] + dev_q[23:16]
                               + dev_q[15:8] + dev_q[7:0] + LANE_ID;
                    byte_cnt  <= 4'd0;
                    stall_cnt <= 32'd0;
                    tx_data   <= 8'h55;
                end
                SEND: begin
                    if (tx_ready) begin
                        byte_cnt  <= nxt_idx;
                        stall_cnt <= 32'd0;
                        tx_data   <= nxt_byte;
                    end else begin
                        stall_cnt <= stall_cnt + 32'd1;
                        if (timeout) tx_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_console_usb_send.sv
// Bench for console_usb_send: lanes 3 and 7 share stimulus; each lane's byte
// stream is scored against packets built from the field rules.
module tb_console_usb_send;

    logic        clk = 1'b0;
    logic        rst;
    logic        fs_send;
    logic [3:0]  send_btype;
    logic [3:0]  data_idx;
    logic [31:0] device_idx;
    logic        tx_ready = 1'b0;
    logic [7:0]  tx_data [2];
    logic        tx_valid [2];
    logic        fd_send [2];
    logic        tx_err [2];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int rdy_mode = 0;
    int hs_total = 0;
    int hs_base = 0;
    int b8_cyc = 0;
    int first_cyc = 0;
    int stall_total [2] = '{0, 0};
    int stall_base [2] = '{0, 0};
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];
    logic [7:0] exp_b;
    logic       have_exp;
    logic [1:0] pat_i = 2'd0;
    logic [3:0] pat = 4'b1001;
    logic       held [2] = '{1'b0, 1'b0};
    logic [7:0] prev_data [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    console_usb_send #(.LANE_ID(8'h03), .TIMEOUT_NUM(32'd16)) dut3 (
        .clk(clk), .rst(rst), .fs_send(fs_send), .fd_send(fd_send[0]),
        .send_btype(send_btype), .data_idx(data_idx), .device_idx(device_idx),
        .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready), .tx_err(tx_err[0])
    );

    console_usb_send #(.LANE_ID(8'h07), .TIMEOUT_NUM(32'd16)) dut7 (
        .clk(clk), .rst(rst), .fs_send(fs_send), .fd_send(fd_send[1]),
        .send_btype(send_btype), .data_idx(data_idx), .device_idx(device_idx),
        .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready), .tx_err(tx_err[1])
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference packet: header, fields, lane, then the mod-256 sum of bytes 2..7.
    task automatic push_pkt(input logic [3:0] bt, input logic [3:0] di, input logic [31:0] dv);
        int b [9];
        int sum;
        for (int l = 0; l < 2; l++) begin
            b[0] = 'h55;
            b[1] = 'hAA;
            b[2] = bt * 16 + di;
            b[3] = (dv >> 24) & 'hFF;
            b[4] = (dv >> 16) & 'hFF;
            b[5] = (dv >> 8) & 'hFF;
            b[6] = dv & 'hFF;
            b[7] = (l == 0) ? 3 : 7;
            sum = 0;
            for (int i = 2; i < 8; i++) sum += b[i];
            b[8] = sum % 256;
            for (int i = 0; i < 9; i++) begin
                if (l == 0) exp_q0.push_back(8'(b[i]));
                else        exp_q1.push_back(8'(b[i]));
            end
        end
    endtask

    // Ready generation and byte scoreboard, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            case (rdy_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = pat[pat_i];
                2:       tx_ready = ($urandom_range(0, 3) != 0);
                default: tx_ready = ((hs_total - hs_base) < 3);
            endcase
            pat_i = pat_i + 2'd1;
            for (int d = 0; d < 2; d++) begin
                if (tx_valid[d]) begin
                    if (held[d]) check(d == 0 ? "stall_stable_l3" : "stall_stable_l7", tx_data[d], prev_data[d]);
                    if (tx_ready) begin
                        have_exp = (d == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
                        if (!have_exp) begin
                            check(d == 0 ? "extra_byte_l3" : "extra_byte_l7", 1, 0);
                        end else begin
                            exp_b = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                            check(d == 0 ? "byte_l3" : "byte_l7", tx_data[d], exp_b);
                        end
                        if (d == 0) begin
                            hs_total++;
                            if ((hs_total - hs_base) == 9) b8_cyc = cyc;
                        end
                    end else begin
                        stall_total[d]++;
                    end
                    held[d] = !tx_ready;
                    prev_data[d] = tx_data[d];
                end else begin
                    held[d] = 1'b0;
                end
            end
        end
    end

    // Called at a negedge; leaves the bench at the negedge showing B0.
    task automatic start_pkt(input logic [3:0] bt, input logic [3:0] di, input logic [31:0] dv);
        push_pkt(bt, di, dv);
        hs_base = hs_total;
        stall_base[0] = stall_total[0];
        stall_base[1] = stall_total[1];
        send_btype = bt;
        data_idx   = di;
        device_idx = dv;
        fs_send    = 1'b1;
        @(negedge clk);
        check("load_no_valid", tx_valid[0], 0);
        check("err_cleared", {tx_err[1], tx_err[0]}, 2'b00);
        send_btype = 4'($urandom);
        data_idx   = 4'($urandom);
        device_idx = $urandom;
        @(negedge clk);
        check("first_valid_lat2", {tx_valid[1], tx_valid[0]}, 2'b11);
        first_cyc = cyc;
    endtask

    task automatic wait_done(input int exp_len, input bit aborted);
        int n = 0;
        while (fd_send[0] !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("fd_rise_in_budget", n < 300, 1);
        check("fd_both_lanes", fd_send[1], 1);
        check("valid_low_in_done", {tx_valid[1], tx_valid[0]}, 2'b00);
        if (!aborted) begin
            check("fd_after_b8", cyc - b8_cyc, 1);
            check("all_bytes_sent", exp_q0.size() + exp_q1.size(), 0);
        end
        if (exp_len > 0) check("packet_cycles", cyc - first_cyc, exp_len);
    endtask

    task automatic release_req(input int hold);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("fd_held", fd_send[0], 1);
        end
        fs_send = 1'b0;
        @(negedge clk);
        check("fd_fall", {fd_send[1], fd_send[0]}, 2'b00);
    endtask

    initial begin
        rst = 1'b1;
        fs_send = 1'b0;
        send_btype = 4'h0;
        data_idx = 4'h0;
        device_idx = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_fd", {fd_send[1], fd_send[0]}, 2'b00);
        check("rst_valid", {tx_valid[1], tx_valid[0]}, 2'b00);
        check("rst_data", {tx_data[1], tx_data[0]}, 16'h0000);
        check("rst_err", {tx_err[1], tx_err[0]}, 2'b00);
        rst = 1'b0;
        @(negedge clk);

        // Basic packet: 55 AA B5 13 57 9B DF 03 9C on lane 3.
        rdy_mode = 0;
        start_pkt(4'hB, 4'h5, 32'h13579BDF);
        wait_done(9, 1'b0);
        release_req(0);

        // Backpressure 1-0-0-1 on the same packet.
        rdy_mode = 1;
        start_pkt(4'hB, 4'h5, 32'h13579BDF);
        wait_done(0, 1'b0);
        release_req(2);

        // Checksum wrap: lane 7 checksum becomes 02.
        rdy_mode = 0;
        start_pkt(4'hF, 4'hF, 32'hFFFFFFFF);
        wait_done(9, 1'b0);
        release_req(1);

        // Random fields under random backpressure.
        rdy_mode = 2;
        for (int k = 0; k < 6; k++) begin
            start_pkt(4'($urandom), 4'($urandom), $urandom);
            wait_done(0, 1'b0);
            release_req($urandom_range(0, 3));
        end

        // Timeout: ready stays low from B3 onward.
        rdy_mode = 3;
        start_pkt(4'h9, 4'h2, $urandom);
        wait_done(0, 1'b1);
        check("timeout_stalls_l3", stall_total[0] - stall_base[0], 16);
        check("timeout_stalls_l7", stall_total[1] - stall_base[1], 16);
        check("timeout_err", {tx_err[1], tx_err[0]}, 2'b11);
        check("timeout_unsent", exp_q0.size() + exp_q1.size(), 12);
        exp_q0.delete();
        exp_q1.delete();
        release_req(1);
        check("err_sticky_idle", tx_err[0], 1);
        rdy_mode = 0;
        start_pkt(4'h1, 4'h3, $urandom);
        wait_done(9, 1'b0);
        release_req(0);

        // Early release during B4, then back-to-back restart on the IDLE cycle.
        start_pkt(4'hB, 4'h5, $urandom);
        repeat (4) @(negedge clk);
        fs_send = 1'b0;
        wait_done(9, 1'b0);
        @(negedge clk);
        check("done_one_cycle", fd_send[0], 0);
        start_pkt(4'h1, 4'h5, $urandom);
        wait_done(9, 1'b0);
        release_req(0);

        // Asynchronous reset while B5 is on the bus.
        start_pkt(4'h9, 4'h7, $urandom);
        repeat (5) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("arst_valid", {tx_valid[1], tx_valid[0]}, 2'b00);
        check("arst_fd", {fd_send[1], fd_send[0]}, 2'b00);
        check("arst_data", {tx_data[1], tx_data[0]}, 16'h0000);
        exp_q0.delete();
        exp_q1.delete();
        fs_send = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start_pkt(4'hB, 4'hA, $urandom);
        wait_done(9, 1'b0);
        release_req(0);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
